// File: rtl/wb_regfile_if.sv
// Write-back bus bundle: W-stage commit inputs plus the two decode read ports.
// The regfile side uses the slave modport; the pipeline side uses master.
interface wb_regfile_if #(
    parameter int DATA_W = 64
);
    logic [DATA_W-1:0] W_valE;
    logic [DATA_W-1:0] W_valM;
    logic [3:0]        W_icode;
    logic [3:0]        W_dstE;
    logic [3:0]        W_dstM;
    logic [3:0]        W_stat;
    logic [3:0]        d_srcA;
    logic [3:0]        d_srcB;
    logic [DATA_W-1:0] d_rvalA;
    logic [DATA_W-1:0] d_rvalB;

    modport master (
        output W_valE, W_valM, W_icode, W_dstE, W_dstM, W_stat, d_srcA, d_srcB,
        input  d_rvalA, d_rvalB
    );

    modport slave (
        input  W_valE, W_valM, W_icode, W_dstE, W_dstM, W_stat, d_srcA, d_srcB,
        output d_rvalA, d_rvalB
    );
endinterface

// File: rtl/wb_regfile.sv
// Write-back stage: architectural register file, run/halt/fault status and retire counter.
// Optional WB_READ_BYPASS_EN makes the read ports return the value committed this cycle.
module wb_regfile #(
    parameter int NUM_REGS = 15,
    parameter int DATA_W   = 64,
    parameter int CNT_W    = 32
) (
    input  logic             clock,
    input  logic             reset_n,
    wb_regfile_if.slave      wb,
    output logic [3:0]       prog_stat,
    output logic             halted,
    output logic [CNT_W-1:0] retired_count
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    localparam logic [3:0] RNONE = 4'hF;

    state_t              state_r;
    state_t              state_s;
    logic [3:0]          prog_stat_r;
    logic [3:0]          prog_stat_s;
    logic [CNT_W-1:0]    count_r;
    logic [DATA_W-1:0]   regs_r [NUM_REGS];
    logic                commit_s;
    logic                we_e_s;
    logic                we_m_s;
    logic                retire_s;
    logic [DATA_W-1:0]   rval_a_s;
    logic [DATA_W-1:0]   rval_b_s;

    // Only an AOK instruction seen while running may commit or retire.
    assign commit_s = (state_r == ST_RUN) && (wb.W_stat == 4'h1);
    assign we_e_s   = commit_s && (wb.W_dstE != RNONE);
    assign we_m_s   = commit_s && (wb.W_dstM != RNONE);
    assign retire_s = commit_s && (wb.W_icode != 4'h1);

    // Next-state and status decode; HALT/FAULT are sticky until reset.
    always_comb begin
        state_s     = state_r;
        prog_stat_s = prog_stat_r;
        case (state_r)
            ST_RUN: begin
                case (wb.W_stat)
                    4'h0, 4'h1: begin
                        state_s     = ST_RUN;
                        prog_stat_s = prog_stat_r;
                    end
                    4'h2: begin
                        state_s     = ST_HALT;
                        prog_stat_s = 4'h2;
                    end
                    4'h3: begin
                        state_s     = ST_FAULT;
                        prog_stat_s = 4'h3;
                    end
                    default: begin
                        state_s     = ST_FAULT;
                        prog_stat_s = 4'h4;
                    end
                endcase
            end
            ST_HALT:  state_s = ST_HALT;
            ST_FAULT: state_s = ST_FAULT;
            default: begin
                state_s     = ST_FAULT;
                prog_stat_s = 4'h4;
            end
        endcase
    end

    // State, status and retire counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_RUN;
            prog_stat_r <= 4'h1;
            count_r     <= {CNT_W{1'b0}};
        end else begin
            state_r     <= state_s;
            prog_stat_r <= prog_stat_s;
            if (retire_s) begin
                count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                count_r <= count_r;
            end
        end
    end

    // Register file write; M port wins when both ports target the same register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we_m_s && (wb.W_dstM == 4'(i))) begin
                    regs_r[i] <= wb.W_valM;
                end else if (we_e_s && (wb.W_dstE == 4'(i))) begin
                    regs_r[i] <= wb.W_valE;
                end else begin
                    regs_r[i] <= regs_r[i];
                end
            end
        end
    end

    // Combinational read ports; an ID outside 0..NUM_REGS-1 (RNONE) reads zero.
    always_comb begin
        rval_a_s = {DATA_W{1'b0}};
        rval_b_s = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            rval_a_s = (wb.d_srcA == 4'(i)) ? regs_r[i] : rval_a_s;
            rval_b_s = (wb.d_srcB == 4'(i)) ? regs_r[i] : rval_b_s;
        end
`ifdef WB_READ_BYPASS_EN
        if (we_m_s && (wb.W_dstM == wb.d_srcA)) begin
            rval_a_s = wb.W_valM;
        end else if (we_e_s && (wb.W_dstE == wb.d_srcA)) begin
            rval_a_s = wb.W_valE;
        end else begin
            rval_a_s = rval_a_s;
        end
        if (we_m_s && (wb.W_dstM == wb.d_srcB)) begin
            rval_b_s = wb.W_valM;
        end else if (we_e_s && (wb.W_dstE == wb.d_srcB)) begin
            rval_b_s = wb.W_valE;
        end else begin
            rval_b_s = rval_b_s;
        end
`endif
    end

    assign wb.d_rvalA    = rval_a_s;
    assign wb.d_rvalB    = rval_b_s;
    assign prog_stat     = prog_stat_r;
    assign halted        = (state_r != ST_RUN);
    assign retired_count = count_r;
endmodule

// File: tb/tb_wb_regfile.sv
// Bench for wb_regfile: directed vector table, mid-cycle reset, fault, then random traffic
// checked against an array-based architectural model.
module tb_wb_regfile;
    logic        clock;
    logic        reset_n;
    logic [3:0]  prog_stat;
    logic        halted;
    logic [31:0] retired_count;

    int checks = 0;
    int errors = 0;

`ifdef WB_READ_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    wb_regfile_if #(.DATA_W(64)) wb ();

    wb_regfile #(.NUM_REGS(15), .DATA_W(64), .CNT_W(32)) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .wb            (wb.slave),
        .prog_stat     (prog_stat),
        .halted        (halted),
        .retired_count (retired_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [3:0]  dst_e;
        logic [3:0]  dst_m;
        logic [63:0] val_e;
        logic [63:0] val_m;
        logic [3:0]  src_a;
        logic [3:0]  src_b;
        logic [63:0] exp_rb;
        logic [3:0]  exp_prog;
        logic        exp_halted;
        logic [31:0] exp_count;
    } vec_t;

    // Architectural model: 15 registers, status code (1 = running), retire count.
    logic [63:0] m_regs [15];
    logic [3:0]  m_stat;
    logic [31:0] m_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] stat, input logic [3:0] icode,
                                input logic [3:0] de, input logic [3:0] dm,
                                input logic [63:0] ve, input logic [63:0] vm,
                                input logic [3:0] sa, input logic [3:0] sb,
                                input logic [63:0] erb, input logic [3:0] ep,
                                input logic eh, input logic [31:0] ec);
        vec_t v;
        v.stat = stat; v.icode = icode; v.dst_e = de; v.dst_m = dm;
        v.val_e = ve; v.val_m = vm; v.src_a = sa; v.src_b = sb;
        v.exp_rb = erb; v.exp_prog = ep; v.exp_halted = eh; v.exp_count = ec;
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 15; i++) m_regs[i] = 64'd0;
        m_stat  = 4'd1;
        m_count = 32'd0;
    endtask

    task automatic model_step(input vec_t v);
        if (m_stat == 4'd1) begin
            if (v.stat == 4'd1) begin
                if (v.dst_e != 4'hF) m_regs[v.dst_e] = v.val_e;
                if (v.dst_m != 4'hF) m_regs[v.dst_m] = v.val_m;
                if (v.icode != 4'd1) m_count = m_count + 32'd1;
            end else if (v.stat == 4'd2) m_stat = 4'd2;
            else if (v.stat == 4'd3) m_stat = 4'd3;
            else if (v.stat >= 4'd4) m_stat = 4'd4;
        end
    endtask

    function automatic logic [63:0] model_read(input vec_t v, input logic [3:0] src);
        if (src == 4'hF) return 64'd0;
        if (BYP && m_stat == 4'd1 && v.stat == 4'd1) begin
            if (v.dst_m == src) return v.val_m;
            if (v.dst_e == src) return v.val_e;
        end
        return m_regs[src];
    endfunction

    task automatic drive_bubble();
        wb.W_stat = 4'd0; wb.W_icode = 4'd0; wb.W_dstE = 4'hF; wb.W_dstM = 4'hF;
        wb.W_valE = 64'd0; wb.W_valM = 64'd0; wb.d_srcA = 4'hF; wb.d_srcB = 4'hF;
    endtask

    // One W-stage cycle: drive at negedge, check reads before the edge, status after it.
    task automatic apply(input vec_t v, input string name, input bit use_tbl);
        @(negedge clock);
        wb.W_stat = v.stat; wb.W_icode = v.icode; wb.W_dstE = v.dst_e; wb.W_dstM = v.dst_m;
        wb.W_valE = v.val_e; wb.W_valM = v.val_m; wb.d_srcA = v.src_a; wb.d_srcB = v.src_b;
        #1;
        chk({name, "_rvalA"}, wb.d_rvalA, model_read(v, v.src_a));
        chk({name, "_rvalB"}, wb.d_rvalB, model_read(v, v.src_b));
        if (use_tbl) chk({name, "_rvalB_tbl"}, wb.d_rvalB, v.exp_rb);
        @(posedge clock);
        model_step(v);
        #1;
        chk({name, "_prog_stat"}, {60'd0, prog_stat}, {60'd0, m_stat});
        chk({name, "_halted"}, {63'd0, halted}, {63'd0, (m_stat != 4'd1)});
        chk({name, "_count"}, {32'd0, retired_count}, {32'd0, m_count});
        if (use_tbl) begin
            chk({name, "_prog_tbl"}, {60'd0, prog_stat}, {60'd0, v.exp_prog});
            chk({name, "_halted_tbl"}, {63'd0, halted}, {63'd0, v.exp_halted});
            chk({name, "_count_tbl"}, {32'd0, retired_count}, {32'd0, v.exp_count});
        end
    endtask

    // Assert reset mid-cycle; it must act at once and clear every register.
    task automatic do_reset();
        @(negedge clock);
        drive_bubble();
        #2 reset_n = 1'b0;
        model_reset();
        #1;
        chk("rst_prog_stat", {60'd0, prog_stat}, 64'd1);
        chk("rst_halted", {63'd0, halted}, 64'd0);
        chk("rst_count", {32'd0, retired_count}, 64'd0);
        for (int i = 0; i < 15; i++) begin
            wb.d_srcA = 4'(i);
            #1 chk("rst_reg_zero", wb.d_rvalA, 64'd0);
        end
        @(negedge clock);
        #3 reset_n = 1'b1;
    endtask

    vec_t tbl [9];
    vec_t rv;

    initial begin
        reset_n = 1'b0;
        drive_bubble();
        model_reset();
        repeat (2) @(posedge clock);
        @(negedge clock);
        #2 reset_n = 1'b1;

        do_reset();

        tbl[0] = mk(4'd1, 4'd2, 4'd3, 4'hF, 64'h1234, 64'h0, 4'd3, 4'hF,
                    64'h0, 4'd1, 1'b0, 32'd1);
        tbl[1] = mk(4'd1, 4'd5, 4'd4, 4'd4, 64'hAA, 64'hBB, 4'd3, 4'd4,
                    BYP ? 64'hBB : 64'h0, 4'd1, 1'b0, 32'd2);
        tbl[2] = mk(4'd0, 4'd2, 4'd2, 4'hF, 64'h77, 64'h0, 4'd4, 4'd2,
                    64'h0, 4'd1, 1'b0, 32'd2);
        tbl[3] = mk(4'd1, 4'd1, 4'hF, 4'hF, 64'h0, 64'h0, 4'd2, 4'd4,
                    64'hBB, 4'd1, 1'b0, 32'd2);
        tbl[4] = mk(4'd1, 4'd3, 4'd6, 4'hF, 64'h55, 64'h0, 4'hF, 4'd6,
                    BYP ? 64'h55 : 64'h0, 4'd1, 1'b0, 32'd3);
        tbl[5] = mk(4'd2, 4'd0, 4'd5, 4'hF, 64'h99, 64'h0, 4'd5, 4'd6,
                    64'h55, 4'd2, 1'b1, 32'd3);
        tbl[6] = mk(4'd1, 4'd2, 4'd5, 4'd5, 64'h11, 64'h22, 4'd5, 4'd3,
                    64'h1234, 4'd2, 1'b1, 32'd3);
        tbl[7] = mk(4'd3, 4'd2, 4'd6, 4'hF, 64'h33, 64'h0, 4'd5, 4'd6,
                    64'h55, 4'd2, 1'b1, 32'd3);
        tbl[8] = mk(4'd0, 4'd0, 4'hF, 4'hF, 64'h0, 64'h0, 4'd4, 4'd5,
                    64'h0, 4'd2, 1'b1, 32'd3);
        for (int i = 0; i < 9; i++) apply(tbl[i], $sformatf("vec%0d", i), 1'b1);

        // Illegal status code faults with INS.
        do_reset();
        apply(mk(4'd7, 4'd2, 4'd1, 4'hF, 64'h42, 64'h0, 4'd1, 4'hF,
                 64'h0, 4'd4, 1'b1, 32'd0), "fault7", 1'b1);
        apply(mk(4'd1, 4'd2, 4'd1, 4'hF, 64'h43, 64'h0, 4'd1, 4'hF,
                 64'h0, 4'd4, 1'b1, 32'd0), "fault_hold", 1'b1);

        do_reset();
        for (int n = 0; n < 600; n++) begin
            int x;
            x = $urandom_range(0, 99);
            rv.stat  = (x < 55) ? 4'd1 : (x < 92) ? 4'd0 : (x < 94) ? 4'd2 :
                       (x < 96) ? 4'd3 : 4'($urandom_range(4, 15));
            rv.icode = 4'($urandom_range(0, 15));
            rv.dst_e = 4'($urandom_range(0, 15));
            rv.dst_m = ($urandom_range(0, 3) == 0) ? rv.dst_e : 4'($urandom_range(0, 15));
            rv.val_e = {$urandom, $urandom};
            rv.val_m = {$urandom, $urandom};
            rv.src_a = ($urandom_range(0, 1) == 0) ? rv.dst_e : 4'($urandom_range(0, 15));
            rv.src_b = ($urandom_range(0, 1) == 0) ? rv.dst_m : 4'($urandom_range(0, 15));
            rv.exp_rb = 64'd0; rv.exp_prog = 4'd0; rv.exp_halted = 1'b0; rv.exp_count = 32'd0;
            apply(rv, "rand", 1'b0);
            if (m_stat != 4'd1 && $urandom_range(0, 7) == 0) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
